// File: rtl/mul_seq_pkg.sv
// Shared types for the multiplier stream sequencer: FSM encoding and FIFO entry sizing.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        CAPT  = 2'd3
    } seq_state_t;

    // One FIFO entry carries both operands plus the tag.
    function automatic int entry_width(input int n, input int tag_w);
        return n * 2 + tag_w;
    endfunction

endpackage

// File: rtl/mul_stream_sequencer_fifo.sv
// Small synchronous FIFO holding operand pairs and tags; pointers carry an extra wrap bit.
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Flags decode from registered pointers only, so a pop frees a slot one cycle later.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mul_stream_sequencer.sv
// Issue/collect stage in front of a start/done serial multiplier: buffers operand pairs,
// runs one multiply at a time, and returns tagged products on a valid/ready stream.
module mul_stream_sequencer
    import mul_seq_pkg::*;
#(
    parameter int N       = 4,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    // Both streams: a transfer happens on a rising edge where valid && ready; the
    // source holds payload steady while valid is high and ready is low.
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             mul_start,
    output logic [N-1:0]     mul_a,
    output logic [N-1:0]     mul_b,
    input  logic [2*N-1:0]   mul_result,
    input  logic             mul_done,
    output logic             err_timeout,
    output logic [15:0]      ops_done,
    output seq_state_t       dbg_state
);

    localparam int EW = entry_width(N, TAG_W);
    localparam int CW = $clog2(TIMEOUT + 1);

    seq_state_t       state;
    logic [TAG_W-1:0] tag_q;
    logic [CW-1:0]    wait_cnt;
    logic [EW-1:0]    fifo_wdata;
    logic [EW-1:0]    fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             out_load;

    assign fifo_wdata = {in_tag, in_a, in_b};
    assign in_ready   = !fifo_full;
    assign fifo_pop   = (state == IDLE) && !fifo_empty;
    assign out_load   = (state == CAPT) && (!out_valid || out_ready);
    assign dbg_state  = state;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            tag_q       <= '0;
            wait_cnt    <= '0;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_tag     <= '0;
            err_timeout <= 1'b0;
            ops_done    <= '0;
        end else begin
            mul_start <= 1'b0;
            // A drain clears the holding register; a same-cycle load in CAPT overrides this.
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        {tag_q, mul_a, mul_b} <= fifo_rdata;
                        mul_start             <= 1'b1;
                        state                 <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // done is ignored on the first WAIT cycle in case it is stale from the last op.
                    if (wait_cnt != '0 && mul_done) begin
                        state <= CAPT;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                CAPT: begin
                    if (out_load) begin
                        out_result <= mul_result;
                        out_tag    <= tag_q;
                        out_valid  <= 1'b1;
                        ops_done   <= ops_done + 16'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_stream_sequencer.sv
// Bench for mul_stream_sequencer with a behavioural start/done multiplier beside it.
module tb_mul_stream_sequencer;
    import mul_seq_pkg::*;

    localparam int N       = 4;
    localparam int TAG_W   = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int RW      = 2 * N;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     in_a = '0;
    logic [N-1:0]     in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [RW-1:0]    out_result;
    logic [TAG_W-1:0] out_tag;
    logic             mul_start;
    logic [N-1:0]     mul_a;
    logic [N-1:0]     mul_b;
    logic [RW-1:0]    mul_result;
    logic             mul_done;
    logic             err_timeout;
    logic [15:0]      ops_done;
    seq_state_t       dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [TAG_W+RW-1:0] exp_q[$];
    logic [TAG_W+RW-1:0] rx_q[$];
    int rx_count    = 0;
    int start_cnt   = 0;
    int push_cnt    = 0;
    int wait_cycles = 0;
    bit stub        = 1'b0;
    bit rand_done   = 1'b0;

    typedef struct {
        logic [N-1:0]     a;
        logic [N-1:0]     b;
        logic [TAG_W-1:0] tag;
        logic [RW-1:0]    res;
    } vec_t;
    vec_t vecs[5];

    mul_stream_sequencer #(
        .N(N), .TAG_W(TAG_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_done(mul_done),
        .err_timeout(err_timeout), .ops_done(ops_done), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    function automatic logic [RW-1:0] prod_of(input logic [N-1:0] a, input logic [N-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[RW-1:0];
    endfunction

    // ---------------- multiplier model: done N cycles after start, level until next start ----------------
    logic [RW-1:0] m_res;
    logic          m_done;
    logic          m_busy;
    int            m_cnt;
    logic [N-1:0]  m_a;
    logic [N-1:0]  m_b;

    always @(posedge clk) begin
        if (rst) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
            m_res  <= '0;
            m_cnt  <= 0;
            m_a    <= '0;
            m_b    <= '0;
        end else if (mul_start) begin
            m_done <= 1'b0;
            m_busy <= 1'b1;
            m_cnt  <= 0;
            m_a    <= mul_a;
            m_b    <= mul_b;
        end else if (m_busy) begin
            if (m_cnt == N - 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_res  <= prod_of(m_a, m_b);
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    assign mul_result = m_res;
    assign mul_done   = stub ? 1'b0 : m_done;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Scoreboard: every accepted pair owes one product, in order.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            rx_count  = 0;
            start_cnt = 0;
            push_cnt  = 0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back({in_tag, prod_of(in_a, in_b)});
                push_cnt++;
            end
            if (mul_start) start_cnt++;
            if (dbg_state == WAIT) wait_cycles++;
            if (out_valid && out_ready) begin
                rx_q.push_back({out_tag, out_result});
                rx_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_extra: got tag %0h result %0h, expected no output", out_tag, out_result);
                end else begin
                    check("sb_output", 32'({out_tag, out_result}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [TAG_W-1:0] tag);
        bit ok = 1'b0;
        in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL push_accept: got in_ready stuck 0, expected tag %0h accepted", tag);
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 600 && !ok; k++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && (dbg_state == IDLE) && !out_valid;
        end
        check(name, 32'(ok), 32'd1);
        step();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0] = '{a: 4'd3, b: 4'hE, tag: 4'd5, res: 8'hFA};
        vecs[1] = '{a: 4'h8, b: 4'h8, tag: 4'd0, res: 8'h40};
        vecs[2] = '{a: 4'd7, b: 4'd7, tag: 4'd1, res: 8'h31};
        vecs[3] = '{a: 4'hF, b: 4'd1, tag: 4'd2, res: 8'hFF};
        vecs[4] = '{a: 4'd0, b: 4'd5, tag: 4'd3, res: 8'h00};

        repeat (3) step();
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mul_start", 32'(mul_start), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        check("rst_ops_done", 32'(ops_done), 32'd0);
        check("rst_out_result", 32'({out_tag, out_result}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));

        // Table: single op then four back-to-back that fill the FIFO behind it.
        out_ready = 1'b1;
        rx_q.delete();
        foreach (vecs[i]) push_op(vecs[i].a, vecs[i].b, vecs[i].tag);
        check("full_in_ready", 32'(in_ready), 32'd0);
        wait_idle("table_drain");
        check("table_count", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            check($sformatf("table_res_%0d", i), 32'(rx_q[i]), 32'({vecs[i].tag, vecs[i].res}));
        end
        check("table_ops_done", 32'(ops_done), 32'd5);
        check("table_starts", 32'(start_cnt), 32'd5);

        // Backpressure: two ops with consumer stalled.
        out_ready = 1'b0;
        push_op(4'd2, 4'd3, 4'd1);
        push_op(4'hD, 4'd5, 4'd2);
        begin
            bit ok = 1'b0;
            for (int k = 0; k < 100 && !ok; k++) begin
                step();
                ok = out_valid && (dbg_state == CAPT);
            end
            check("bp_reach_capt", 32'(ok), 32'd1);
        end
        repeat (5) step();
        check("bp_hold_result", 32'({out_tag, out_result}), 32'({4'd1, 8'h06}));
        check("bp_hold_state", 32'(dbg_state), 32'(CAPT));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_reload_valid", 32'(out_valid), 32'd1);
        check("bp_second_result", 32'({out_tag, out_result}), 32'({4'd2, 8'hF1}));
        check("bp_state_idle", 32'(dbg_state), 32'(IDLE));
        out_ready = 1'b1;
        wait_idle("bp_drain");
        check("bp_ops_done", 32'(ops_done), 32'(rx_count));

        // Random traffic with random consumer stalls.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    push_op(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)), TAG_W'($urandom_range(0, 15)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    step();
                end
                out_ready = 1'b1;
            end
        join
        wait_idle("rand_drain");
        check("rand_ops_done", 32'(ops_done), 32'(rx_count));
        check("rand_starts", 32'(start_cnt), 32'(push_cnt));

        // Watchdog: multiplier never reports done.
        stub = 1'b1;
        wait_cycles = 0;
        push_op(4'd1, 4'd1, 4'd7);
        begin
            bit ok = 1'b0;
            for (int k = 0; k < 100 && !ok; k++) begin
                step();
                ok = err_timeout;
            end
            check("to_err_set", 32'(ok), 32'd1);
        end
        check("to_wait_cycles", 32'(wait_cycles), 32'(TIMEOUT));
        check("to_state_idle", 32'(dbg_state), 32'(IDLE));
        check("to_dropped_pending", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        stub = 1'b0;
        push_op(4'd5, 4'hF, 4'd8);
        wait_idle("to_next_drain");
        check("to_next_result", 32'(rx_q[$]), 32'({4'd8, 8'hFB}));
        check("to_err_sticky", 32'(err_timeout), 32'd1);
        check("to_ops_done", 32'(ops_done), 32'(rx_count));

        // Reset during WAIT with two entries queued.
        push_op(4'd2, 4'd2, 4'd1);
        push_op(4'd3, 4'd3, 4'd2);
        push_op(4'd4, 4'd4, 4'd3);
        begin
            bit ok = 1'b0;
            for (int k = 0; k < 50 && !ok; k++) begin
                ok = (dbg_state == WAIT);
                if (!ok) step();
            end
            check("mid_reach_wait", 32'(ok), 32'd1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_state", 32'(dbg_state), 32'(IDLE));
        check("mid_in_ready", 32'(in_ready), 32'd1);
        check("mid_err_cleared", 32'(err_timeout), 32'd0);
        check("mid_ops_done", 32'(ops_done), 32'd0);
        repeat (30) step();
        check("mid_no_start", 32'(start_cnt), 32'd0);
        check("mid_no_output", 32'(rx_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
